uart_cmd_bridge: RTL and testbench
==================================

// Module: uart_cmd_bridge
// PURPOSE
//  Command responder on the host side of the uart byte interface: consumes RxData/RxValid,
//  decodes register read/write commands, drives an 8-bit-address register bus, and returns
//  one reply byte per command through TxData/TxSend. Sits between uart and the register
//  file so a PC terminal can poke GBA-IO debug registers.
// PARAMETERS
//  IDLE_TIMEOUT  2500000  inter-byte timeout in Clk cycles (100 ms at 25 MHz); abort mid-command
//  RD_TIMEOUT    255      max Clk cycles to wait for BusRdValid after BusRd
// PORTS
//  Clk          in   1  clock
//  Reset        in   1  synchronous, active-high reset
//  RxData       in   8  received byte from uart
//  RxValid      in   1  RxData valid
//  RxUnload     out  1  one-cycle pulse: byte consumed
//  TxData       out  8  reply byte to uart
//  TxSend       out  1  one-cycle pulse: load TxData
//  TxEmpty      in   1  uart send buffer empty
//  BusAddr      out  8  register address
//  BusWrData    out  8  write data
//  BusWr        out  1  one-cycle write strobe (accepted same cycle, no ack)
//  BusRd        out  1  one-cycle read strobe
//  BusRdData    in   8  read data, qualified by BusRdValid
//  BusRdValid   in   1  read data valid (1 cycle)
//  Busy         out  1  high in any state other than IDLE
//  TimeoutFlag  out  1  sticky: idle or read timeout occurred; cleared only by Reset
// BEHAVIOUR
//  Reset: state IDLE; RxUnload, TxSend, BusWr, BusRd, Busy, TimeoutFlag = 0; TxData, BusAddr, BusWrData = 0.
//  Protocol: 'W'(0x57) addr data -> bus write, reply 'K'(0x4B); 'R'(0x52) addr -> bus read, reply data.
//   Other opcode in IDLE -> reply '?'(0x3F). Read timeout -> reply 'E'(0x45).
//  Byte consume: in a byte-accepting state with RxValid=1, pulse RxUnload for one cycle and
//   register RxData; the cycle after RxUnload the byte is not re-consumed (RxValid is cleared by uart).
//  States: IDLE -> GET_ADDR (opcode W/R) | SEND ('?'); GET_ADDR -> GET_DATA (W) | BUS_RD (R);
//   GET_DATA -> BUS_WR; BUS_WR -> SEND ('K'); BUS_RD -> WAIT_RD -> SEND (data or 'E'); SEND -> IDLE.
//  BUS_WR: BusWr=1 exactly one cycle, cycle after the data byte's RxUnload.
//  BUS_RD: BusRd=1 one cycle; WAIT_RD counts; BusRdValid in the BusRd cycle or later is accepted.
//   No BusRdValid within RD_TIMEOUT cycles after BusRd -> TxData='E', TimeoutFlag=1.
//  SEND: hold until TxEmpty=1, then TxSend=1 for one cycle with TxData stable; next state IDLE.
//   Write latency: data RxUnload at t -> BusWr at t+1 -> TxSend at t+2 (if TxEmpty).
//  Idle timeout: counter reloads on each consumed byte; in GET_ADDR/GET_DATA(/GET_CSUM), with no
//   RxValid for IDLE_TIMEOUT cycles -> IDLE, no reply, no bus strobe, TimeoutFlag=1.
//  Bytes arriving while in BUS_*/WAIT_RD/SEND stay in uart buffer (not unloaded) until IDLE.
//  BusRdValid outside WAIT_RD/BUS_RD is ignored. Counters saturate, never wrap.
//  Reset mid-command: immediate IDLE, partial command discarded, strobes low next cycle.
// CONFIGURATION
//  UART_CMD_CSUM_EN defined: every command carries a trailing checksum byte = XOR of all prior
//   command bytes (state GET_CSUM before BUS_WR/BUS_RD). Mismatch -> no bus strobe, reply 'E'.
//   Unknown opcode still replies '?' immediately (no checksum expected).
//  Not defined: no GET_CSUM state; commands exactly as listed in BEHAVIOUR.
// TESTING
//  1 W,0x10,0xA5 (TxEmpty=1) -> one BusWr, BusAddr=0x10, BusWrData=0xA5; TxSend with 0x4B 2 cycles later.
//  2 R,0x22; BusRdValid with 0x5C 3 cycles after BusRd -> one BusRd, BusAddr=0x22; reply 0x5C.
//  3 R,0x01, BusRdValid never -> reply 0x45 after RD_TIMEOUT cycles, TimeoutFlag=1.
//  4 0x41 in IDLE -> reply 0x3F, no bus strobe; then W,0x00,0x00 processes normally ('K').
//  5 W,0x10 then silence > IDLE_TIMEOUT (set 100) -> IDLE, no BusWr, no TxSend, TimeoutFlag=1.
//  6 TxEmpty=0 held 50 cycles in SEND -> TxSend waits, fires once when TxEmpty=1; with
//    UART_CMD_CSUM_EN: W,0x10,0xA5,0xE2 -> 'K'; W,0x10,0xA5,0x00 -> 'E', no BusWr.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// UART command responder: 'W' addr data -> bus write + 'K'; 'R' addr -> bus read + data byte.
// Define UART_CMD_CSUM_EN to require a trailing XOR checksum byte on every W/R command.
module uart_cmd_bridge #(
    parameter int IDLE_TIMEOUT = 2500000,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    output logic       RxUnload,
    output logic [7:0] TxData,
    output logic       TxSend,
    input  logic       TxEmpty,
    output logic [7:0] BusAddr,
    output logic [7:0] BusWrData,
    output logic       BusWr,
    output logic       BusRd,
    input  logic [7:0] BusRdData,
    input  logic       BusRdValid,
    output logic       Busy,
    output logic       TimeoutFlag
);
    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_UNK = 8'h3F;
    localparam logic [7:0] RSP_ERR = 8'h45;

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int RW = $clog2(RD_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(RD_TIMEOUT - 1);

`ifdef UART_CMD_CSUM_EN
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, GET_CSUM, BUS_WR, BUS_RD, WAIT_RD, SEND
    } state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, SEND
    } state_t;
`endif

    state_t        state;
    logic          is_wr;
    logic [IW-1:0] idle_cnt;
    logic [RW-1:0] rd_cnt;
    logic          take;
    logic          idle_expired;

    // A byte stays visible for one cycle after RxUnload; never take it twice.
    assign take         = RxValid && !RxUnload;
    assign idle_expired = (idle_cnt == IDLE_LAST);
    assign Busy         = (state != IDLE);

    // NOTE: all state and outputs use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            RxUnload    <= 1'b0;
            TxSend      <= 1'b0;
            BusWr       <= 1'b0;
            BusRd       <= 1'b0;
            TimeoutFlag <= 1'b0;
            TxData      <= 8'h00;
            BusAddr     <= 8'h00;
            BusWrData   <= 8'h00;
            is_wr       <= 1'b0;
            idle_cnt    <= '0;
            rd_cnt      <= '0;
`ifdef UART_CMD_CSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            RxUnload <= 1'b0;
            TxSend   <= 1'b0;
            BusWr    <= 1'b0;
            BusRd    <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    RxUnload <= 1'b1;
                    idle_cnt <= '0;
                    if (RxData == OP_WR || RxData == OP_RD) begin
                        is_wr <= (RxData == OP_WR);
                        state <= GET_ADDR;
`ifdef UART_CMD_CSUM_EN
                        csum  <= RxData;
`endif
                    end else begin
                        TxData <= RSP_UNK;
                        state  <= SEND;
                    end
                end
                GET_ADDR: begin
                    if (take) begin
                        RxUnload <= 1'b1;
                        idle_cnt <= '0;
                        BusAddr  <= RxData;
`ifdef UART_CMD_CSUM_EN
                        csum     <= csum ^ RxData;
                        state    <= is_wr ? GET_DATA : GET_CSUM;
`else
                        state    <= is_wr ? GET_DATA : BUS_RD;
`endif
                    end else if (idle_expired) begin
                        TimeoutFlag <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                GET_DATA: begin
                    if (take) begin
                        RxUnload  <= 1'b1;
                        idle_cnt  <= '0;
                        BusWrData <= RxData;
`ifdef UART_CMD_CSUM_EN
                        csum      <= csum ^ RxData;
                        state     <= GET_CSUM;
`else
                        state     <= BUS_WR;
`endif
                    end else if (idle_expired) begin
                        TimeoutFlag <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
`ifdef UART_CMD_CSUM_EN
                GET_CSUM: begin
                    if (take) begin
                        RxUnload <= 1'b1;
                        idle_cnt <= '0;
                        if (RxData == csum) begin
                            state <= is_wr ? BUS_WR : BUS_RD;
                        end else begin
                            TxData <= RSP_ERR;
                            state  <= SEND;
                        end
                    end else if (idle_expired) begin
                        TimeoutFlag <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
`endif
                BUS_WR: begin
                    BusWr  <= 1'b1;
                    TxData <= RSP_OK;
                    state  <= SEND;
                end
                BUS_RD: begin
                    BusRd  <= 1'b1;
                    rd_cnt <= '0;
                    state  <= WAIT_RD;
                end
                // The first WAIT_RD cycle is the BusRd cycle, so same-cycle data is accepted.
                WAIT_RD: begin
                    if (BusRdValid) begin
                        TxData <= BusRdData;
                        state  <= SEND;
                    end else if (rd_cnt == RD_LAST) begin
                        TxData      <= RSP_ERR;
                        TimeoutFlag <= 1'b1;
                        state       <= SEND;
                    end else begin
                        rd_cnt <= rd_cnt + RW'(1);
                    end
                end
                SEND: if (TxEmpty) begin
                    TxSend <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed vector table, corner sequences, random commands
// against a command-level reference model. Honours UART_CMD_CSUM_EN when defined.
module tb_uart_cmd_bridge;
    localparam int IDLE_TO = 100;
    localparam int RD_TO   = 255;

    typedef logic [7:0] byte_t;
    typedef struct {
        byte_t a;
        byte_t d;
        int    c;
    } ev_t;
    typedef struct {
        byte_t b[4];
        int    n;
        int    lat;
        int    n_wr;
        byte_t wa;
        byte_t wd;
        int    n_rd;
        byte_t ra;
        byte_t reply;
    } vec_t;

    logic  Clk = 1'b0;
    logic  Reset, TxEmpty;
    byte_t RxData, BusRdData;
    logic  RxValid, BusRdValid;
    logic  RxUnload, TxSend, BusWr, BusRd, Busy, TimeoutFlag;
    byte_t TxData, BusAddr, BusWrData;

    uart_cmd_bridge #(.IDLE_TIMEOUT(IDLE_TO), .RD_TIMEOUT(RD_TO)) dut (
        .Clk(Clk), .Reset(Reset), .RxData(RxData), .RxValid(RxValid), .RxUnload(RxUnload),
        .TxData(TxData), .TxSend(TxSend), .TxEmpty(TxEmpty), .BusAddr(BusAddr),
        .BusWrData(BusWrData), .BusWr(BusWr), .BusRd(BusRd), .BusRdData(BusRdData),
        .BusRdValid(BusRdValid), .Busy(Busy), .TimeoutFlag(TimeoutFlag)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    ev_t   wr_log[$], rd_log[$], tx_log[$];
    int    ul_log[$];
    byte_t rx_q[$];
    int    rx_gap  = 0;
    int    rd_lat  = 0;
    bit    rd_rand = 1'b0;
    bit    stray_req = 1'b0;

    function automatic byte_t mem_init(input int i);
        return byte_t'(i * 7 + 3);
    endfunction

    // UART receive side, register-file responder and event logger, all at the falling edge.
    initial begin
        byte_t dev_mem[256];
        int    gap_left = 0;
        bit    rd_pending = 1'b0;
        int    rd_left = 0;
        byte_t rd_addr = 8'h00;
        for (int i = 0; i < 256; i++) dev_mem[i] = mem_init(i);
        RxValid = 1'b0; RxData = 8'h00; BusRdValid = 1'b0; BusRdData = 8'h00;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                RxValid = 1'b0; rx_q.delete(); gap_left = 0;
                BusRdValid = 1'b0; rd_pending = 1'b0;
            end else begin
                if (BusWr)    wr_log.push_back('{BusAddr, BusWrData, cyc});
                if (BusRd)    rd_log.push_back('{BusAddr, 8'h00, cyc});
                if (TxSend)   tx_log.push_back('{8'h00, TxData, cyc});
                if (RxUnload) ul_log.push_back(cyc);

                if (RxUnload) begin
                    RxValid = 1'b0;
                    gap_left = rx_gap;
                end else if (!RxValid) begin
                    if (gap_left > 0) gap_left--;
                    else if (rx_q.size() > 0) begin
                        RxData = rx_q.pop_front();
                        RxValid = 1'b1;
                    end
                end

                BusRdValid = 1'b0;
                if (BusWr) dev_mem[BusAddr] = BusWrData;
                if (BusRd) begin
                    rd_left = rd_rand ? int'($urandom_range(0, 5)) : rd_lat;
                    rd_pending = (rd_left >= 0);
                    rd_addr = BusAddr;
                end
                if (rd_pending) begin
                    if (rd_left == 0) begin
                        BusRdValid = 1'b1;
                        BusRdData = dev_mem[rd_addr];
                        rd_pending = 1'b0;
                    end else rd_left--;
                end else if (stray_req) begin
                    BusRdValid = 1'b1;
                    BusRdData = 8'hEE;
                end
                stray_req = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); tx_log.delete(); ul_log.delete();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(3);
        Reset = 1'b0;
        tick(1);
        clear_logs();
    endtask

    task automatic send_cmd(input byte_t b[4], input int n);
        byte_t x = 8'h00;
        for (int i = 0; i < n; i++) begin
            rx_q.push_back(b[i]);
            x ^= b[i];
        end
`ifdef UART_CMD_CSUM_EN
        if (b[0] == 8'h57 || b[0] == 8'h52) rx_q.push_back(x);
`endif
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check({name, " reply count"}, tx_log.size(), n);
    endtask

    function automatic byte_t tx_at(input int k);
        return (tx_log.size() > k) ? tx_log[k].d : 8'hxx;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[10];
        byte_t model_mem[256];
        byte_t exp_tx[$];
        byte_t exp_rd[$];
        ev_t   exp_wr[$];
        byte_t cmd[4];
        int    ul_last;

        tbl[0] = '{'{8'h57, 8'h10, 8'hA5, 8'h00}, 3, 0, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h4B};
        tbl[1] = '{'{8'h57, 8'h22, 8'h5C, 8'h00}, 3, 0, 1, 8'h22, 8'h5C, 0, 8'h00, 8'h4B};
        tbl[2] = '{'{8'h52, 8'h22, 8'h00, 8'h00}, 2, 3, 0, 8'h00, 8'h00, 1, 8'h22, 8'h5C};
        tbl[3] = '{'{8'h41, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h3F};
        tbl[4] = '{'{8'h57, 8'h00, 8'h00, 8'h00}, 3, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h4B};
        tbl[5] = '{'{8'h52, 8'h10, 8'h00, 8'h00}, 2, 0, 0, 8'h00, 8'h00, 1, 8'h10, 8'hA5};
        tbl[6] = '{'{8'h52, 8'h00, 8'h00, 8'h00}, 2, 5, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00};
        tbl[7] = '{'{8'h72, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h3F};
        tbl[8] = '{'{8'h57, 8'hFF, 8'h3C, 8'h00}, 3, 0, 1, 8'hFF, 8'h3C, 0, 8'h00, 8'h4B};
        tbl[9] = '{'{8'h52, 8'hFF, 8'h00, 8'h00}, 2, 1, 0, 8'h00, 8'h00, 1, 8'hFF, 8'h3C};

        TxEmpty = 1'b1;
        Reset = 1'b1;
        tick(3);
        check("rst RxUnload", RxUnload, 0);
        check("rst TxSend", TxSend, 0);
        check("rst BusWr", BusWr, 0);
        check("rst BusRd", BusRd, 0);
        check("rst Busy", Busy, 0);
        check("rst TimeoutFlag", TimeoutFlag, 0);
        check("rst TxData", TxData, 0);
        check("rst BusAddr", BusAddr, 0);
        check("rst BusWrData", BusWrData, 0);
        Reset = 1'b0;
        tick(2);
        clear_logs();

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            rd_lat = tbl[i].lat;
            clear_logs();
            send_cmd(tbl[i].b, tbl[i].n);
            wait_tx(1, 600, $sformatf("vec%0d", i));
            tick(3);
            check($sformatf("vec%0d reply", i), tx_at(0), tbl[i].reply);
            check($sformatf("vec%0d BusWr count", i), wr_log.size(), tbl[i].n_wr);
            check($sformatf("vec%0d BusRd count", i), rd_log.size(), tbl[i].n_rd);
            check($sformatf("vec%0d Busy after", i), Busy, 0);
            ul_last = (ul_log.size() > 0) ? ul_log[$] : -100;
            if (tbl[i].n_wr == 1 && wr_log.size() == 1 && tx_log.size() == 1) begin
                check($sformatf("vec%0d BusAddr", i), wr_log[0].a, tbl[i].wa);
                check($sformatf("vec%0d BusWrData", i), wr_log[0].d, tbl[i].wd);
                check($sformatf("vec%0d BusWr latency", i), wr_log[0].c - ul_last, 1);
                check($sformatf("vec%0d TxSend latency", i), tx_log[0].c - wr_log[0].c, 1);
            end
            if (tbl[i].n_rd == 1 && rd_log.size() == 1) begin
                check($sformatf("vec%0d rd BusAddr", i), rd_log[0].a, tbl[i].ra);
                check($sformatf("vec%0d BusRd latency", i), rd_log[0].c - ul_last, 1);
            end
        end

        // Stray BusRdValid while idle must be ignored
        clear_logs();
        stray_req = 1'b1;
        tick(4);
        check("stray valid no reply", tx_log.size(), 0);
        check("stray valid idle", Busy, 0);
        rd_lat = 2;
        cmd = '{8'h52, 8'h10, 8'h00, 8'h00};
        send_cmd(cmd, 2);
        wait_tx(1, 600, "post-stray read");
        check("post-stray read data", tx_at(0), 8'hA5);
        tick(3);

        // Reply held while TxEmpty=0, fires exactly once afterwards
        clear_logs();
        TxEmpty = 1'b0;
        cmd = '{8'h57, 8'h10, 8'hA5, 8'h00};
        send_cmd(cmd, 3);
        for (int k = 0; k < 60 && wr_log.size() == 0; k++) tick(1);
        check("hold BusWr seen", wr_log.size(), 1);
        tick(50);
        check("hold no TxSend", tx_log.size(), 0);
        check("hold Busy", Busy, 1);
        check("hold TxData", TxData, 8'h4B);
        TxEmpty = 1'b1;
        tick(3);
        check("hold released reply", tx_at(0), 8'h4B);
        tick(5);
        check("hold single TxSend", tx_log.size(), 1);

        // Inter-byte gaps shorter than the idle timeout are tolerated
        clear_logs();
        rx_gap = 80;
        cmd = '{8'h57, 8'h5A, 8'h69, 8'h00};
        send_cmd(cmd, 3);
        wait_tx(1, 600, "slow write");
        check("slow write reply", tx_at(0), 8'h4B);
        check("slow write BusWr", wr_log.size(), 1);
        check("slow write flag", TimeoutFlag, 0);
        rx_gap = 0;
        tick(3);

`ifdef UART_CMD_CSUM_EN
        clear_logs();
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5); rx_q.push_back(8'hE2);
        wait_tx(1, 200, "csum good");
        check("csum good reply", tx_at(0), 8'h4B);
        check("csum good BusWr", wr_log.size(), 1);
        tick(3);
        clear_logs();
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5); rx_q.push_back(8'h00);
        wait_tx(1, 200, "csum bad");
        check("csum bad reply", tx_at(0), 8'h45);
        check("csum bad no BusWr", wr_log.size(), 0);
        tick(3);
`endif

        // Random commands against a command-level model
        do_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = mem_init(i);
        rd_rand = 1'b1;
        rx_gap = int'($urandom_range(0, 3));
        for (int n = 0; n < 40; n++) begin
            int kind = int'($urandom_range(0, 9));
            byte_t a = byte_t'($urandom);
            byte_t d = byte_t'($urandom);
            if (kind < 4) begin
                cmd = '{8'h57, a, d, 8'h00};
                send_cmd(cmd, 3);
                exp_wr.push_back('{a, d, 0});
                model_mem[a] = d;
                exp_tx.push_back(8'h4B);
            end else if (kind < 8) begin
                cmd = '{8'h52, a, 8'h00, 8'h00};
                send_cmd(cmd, 2);
                exp_rd.push_back(a);
                exp_tx.push_back(model_mem[a]);
            end else begin
                byte_t op = byte_t'($urandom);
                while (op == 8'h57 || op == 8'h52) op = byte_t'($urandom);
                cmd = '{op, 8'h00, 8'h00, 8'h00};
                send_cmd(cmd, 1);
                exp_tx.push_back(8'h3F);
            end
        end
        wait_tx(exp_tx.size(), 20000, "random");
        tick(5);
        check("random BusWr count", wr_log.size(), exp_wr.size());
        check("random BusRd count", rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_tx.size(); i++)
            check($sformatf("random reply %0d", i), tx_at(i), exp_tx[i]);
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("random wr %0d", i), {wr_log[i].a, wr_log[i].d}, {exp_wr[i].a, exp_wr[i].d});
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check($sformatf("random rd addr %0d", i), rd_log[i].a, exp_rd[i]);
        check("random flag", TimeoutFlag, 0);
        rd_rand = 1'b0;
        rx_gap = 0;

        // Read timeout
        clear_logs();
        rd_lat = -1;
        cmd = '{8'h52, 8'h01, 8'h00, 8'h00};
        send_cmd(cmd, 2);
        wait_tx(1, 600, "rd timeout");
        check("rd timeout reply", tx_at(0), 8'h45);
        check("rd timeout flag", TimeoutFlag, 1);
        if (tx_log.size() == 1 && rd_log.size() == 1)
            check("rd timeout wait length",
                  (tx_log[0].c - rd_log[0].c >= RD_TO) && (tx_log[0].c - rd_log[0].c <= RD_TO + 2), 1);
        tick(3);
        rd_lat = 0;

        // Idle timeout mid-command
        do_reset();
        check("reset clears flag", TimeoutFlag, 0);
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h10);
        tick(60);
        check("idle partial Busy", Busy, 1);
        check("idle partial flag", TimeoutFlag, 0);
        tick(80);
        check("idle to Busy", Busy, 0);
        check("idle to flag", TimeoutFlag, 1);
        check("idle to no BusWr", wr_log.size(), 0);
        check("idle to no TxSend", tx_log.size(), 0);

        // Reset mid-command discards the partial command
        do_reset();
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h33);
        tick(6);
        check("mid busy", Busy, 1);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(1);
        check("mid reset Busy", Busy, 0);
        check("mid reset BusWr", BusWr, 0);
        clear_logs();
        cmd = '{8'h57, 8'h44, 8'h99, 8'h00};
        send_cmd(cmd, 3);
        wait_tx(1, 200, "after reset");
        check("after reset reply", tx_at(0), 8'h4B);
        check("after reset BusWr count", wr_log.size(), 1);
        if (wr_log.size() == 1) check("after reset wr", {wr_log[0].a, wr_log[0].d}, 16'h4499);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
